// File: rtl/add_pipe_arb.sv
// add_pipe_arb: shares one pipelined adder among NUM_REQ requesters.
// Issues at most one addition per cycle, records each in-flight operation's
// requester ID in a tag FIFO, and steers results back in issue order. The
// adder's output-stage stall (add_sel) follows the ready of the requester
// whose result sits at the adder output.
//
// Optional build macro: ADD_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest requester index wins, no rr_ptr
//   undefined -> round-robin starting at rr_ptr (default)
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       per-requester issue handshake (ready one-hot)
//   req_a/req_b/req_add_one   per-requester operands, slice i*WIDTH +: WIDTH
//   add_dataA/B, add_addOne   granted operands to the adder
//   add_valid/add_run         adder issue handshake
//   add_result(_valid)        adder output stage
//   add_sel                   adder output-stage advance (low = stall)
//   rsp_valid/rsp_ready       per-requester result handshake (valid one-hot)
//   rsp_data                  shared result bus
//   busy                      work in flight or requested
//   err                       sticky: result arrived with no tag outstanding
module add_pipe_arb #(
  parameter int unsigned WIDTH        = 757,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned MAX_INFLIGHT = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_add_one,
  output logic [WIDTH-1:0]         add_dataA,
  output logic [WIDTH-1:0]         add_dataB,
  output logic                     add_addOne,
  output logic                     add_valid,
  input  logic                     add_run,
  input  logic [WIDTH-1:0]         add_result,
  input  logic                     add_result_valid,
  output logic                     add_sel,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  logic [ID_W-1:0]  gnt;
  logic             any_req;
  logic             space;
  logic             has_tag;
  logic             accept;
  logic             pop;
  logic             head_ready;
  logic [ID_W-1:0]  head;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ID_W-1:0]  tag_mem [MAX_INFLIGHT];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

`ifdef ADD_ARB_FIXED_PRIO_EN
  // Fixed priority: lowest valid index wins.
  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req_valid[k]) begin
        any_req = 1'b1;
        gnt     = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;

  // Round-robin: first pass covers rr_ptr..NUM_REQ-1, second pass wraps to 0.
  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req_valid[k] && (ID_W'(k) >= rr_ptr)) begin
        any_req = 1'b1;
        gnt     = ID_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req_valid[k]) begin
        any_req = 1'b1;
        gnt     = ID_W'(k);
      end
    end
  end

  // Pointer moves just past the requester that was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + ID_W'(1);
    end
  end
`endif

  // Operand mux for the granted requester.
  always_comb begin
    add_dataA  = '0;
    add_dataB  = '0;
    add_addOne = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt == ID_W'(k)) begin
        add_dataA  = req_a[k*WIDTH +: WIDTH];
        add_dataB  = req_b[k*WIDTH +: WIDTH];
        add_addOne = req_add_one[k];
      end
    end
  end

  assign space     = (cnt < CNT_W'(MAX_INFLIGHT));
  assign has_tag   = (cnt != '0);
  assign add_valid = !rst && any_req && space;
  assign accept    = add_valid && add_run;
  assign head      = tag_mem[rd_ptr];

  // Issue accept and result steering, both decoded per requester.
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    head_ready = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = accept && (gnt == ID_W'(k));
      if (head == ID_W'(k)) begin
        head_ready   = rsp_ready[k];
        rsp_valid[k] = !rst && add_result_valid && has_tag;
      end
    end
  end

  // Orphan results (no tag) are drained so the adder never locks up.
  assign add_sel  = rst || !add_result_valid || !has_tag || head_ready;
  assign pop      = !rst && add_result_valid && has_tag && add_sel;
  assign rsp_data = add_result;
  assign busy     = has_tag || (|req_valid);

  // Tag FIFO pointers, in-flight count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      if (accept && !pop)      cnt <= cnt + CNT_W'(1);
      else if (!accept && pop) cnt <= cnt - CNT_W'(1);
      if (add_result_valid && !has_tag) err <= 1'b1;
    end
  end

  // Tag storage needs no reset; validity is tracked by cnt.
  always_ff @(posedge clk) begin
    if (accept) tag_mem[wr_ptr] <= gnt;
  end

endmodule
